// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the decode/execute boundary.
//   XLEN, CTRL_W    datapath and opaque control-bundle widths
//   CTRL_NOP        all-zero control bundle
//   id_ex_t         contents of the ID/EX pipeline register
//   ID_EX_BUBBLE    ID/EX value that carries no instruction
//   writer_hit()    does a writer (we, wn) supply source register src
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   typedef struct packed {
      logic              valid;
      logic              wreg;
      logic              m2reg;
      logic [4:0]        wn;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [XLEN-1:0]   imm;
   } id_ex_t;

   localparam id_ex_t ID_EX_BUBBLE = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0,
                                       wn: 5'd0, ctrl: CTRL_NOP,
                                       a: '0, b: '0, imm: '0};

   // $0 is hard-wired zero, so it never matches a writer.
   function automatic logic writer_hit(input logic       we,
                                       input logic [4:0] wn,
                                       input logic [4:0] src,
                                       input logic       used);
      return we && used && (src != 5'd0) && (wn == src);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector. Present only when FWD_EN is defined.
//   src_i/used_i              source register number and whether it is read
//   ex_*_i, mem_*_i, wb_*_i   the three in-flight writers, youngest first
//   q_i                       register-file read data
//   d_o                       selected operand
//   ex_hit_o                  the EX writer supplies this operand
`ifdef FWD_EN
module fwd_mux
   import pipe_pkg::*;
(
   input  logic [4:0]      src_i,
   input  logic            used_i,
   input  logic            ex_we_i,
   input  logic [4:0]      ex_wn_i,
   input  logic [XLEN-1:0] ex_alu_i,
   input  logic            mem_we_i,
   input  logic [4:0]      mem_wn_i,
   input  logic            mem_m2reg_i,
   input  logic [XLEN-1:0] mem_alu_i,
   input  logic [XLEN-1:0] mem_dout_i,
   input  logic            wb_we_i,
   input  logic [4:0]      wb_wn_i,
   input  logic [XLEN-1:0] wb_d_i,
   input  logic [XLEN-1:0] q_i,
   output logic            ex_hit_o,
   output logic [XLEN-1:0] d_o
);

   logic mem_hit;
   logic wb_hit;

   assign ex_hit_o = writer_hit(ex_we_i, ex_wn_i, src_i, used_i);
   assign mem_hit  = writer_hit(mem_we_i, mem_wn_i, src_i, used_i);
   assign wb_hit   = writer_hit(wb_we_i, wb_wn_i, src_i, used_i);

   // Youngest writer wins.
   always_comb begin
      d_o = q_i;
      if (ex_hit_o)
         d_o = ex_alu_i;
      else if (mem_hit)
         d_o = mem_m2reg_i ? mem_dout_i : mem_alu_i;
      else if (wb_hit)
         d_o = wb_d_i;
   end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// Decode-to-execute operand stage: resolves RAW hazards on the two register
// sources and loads the ID/EX pipeline register.
//   clk, clrn                 clock, async active-low reset
//   rs/rt, *_used, qa/qb      sources and register-file read data
//   id_*                      decoded fields of the instruction in ID
//   ex_alu, mem_*, wb_*       results of in-flight writers
//   flush                     kill the instruction in ID
//   stall                     hold PC and IF/ID this cycle
//   e_*                       ID/EX register outputs
// Build option FWD_EN: when defined, operands are bypassed from EX/MEM/WB and
// only load-use stalls. When undefined, operands come straight from the
// register file and any pending writer of a used source stalls.
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              clrn,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic              rs_used,
   input  logic              rt_used,
   input  logic [XLEN-1:0]   qa,
   input  logic [XLEN-1:0]   qb,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [4:0]        id_wn,
   input  logic              id_wreg,
   input  logic              id_m2reg,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   ex_alu,
   input  logic [4:0]        mem_wn,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [XLEN-1:0]   mem_alu,
   input  logic [XLEN-1:0]   mem_dout,
   input  logic [4:0]        wb_wn,
   input  logic              wb_we,
   input  logic [XLEN-1:0]   wb_d,
   input  logic              flush,
   output logic              stall,
   output logic [XLEN-1:0]   ea,
   output logic [XLEN-1:0]   eb,
   output logic [XLEN-1:0]   e_imm,
   output logic [CTRL_W-1:0] e_ctrl,
   output logic [4:0]        e_wn,
   output logic              e_wreg,
   output logic              e_m2reg,
   output logic              e_valid
);

   id_ex_t          e_q;
   id_ex_t          e_d;
   logic            ex_we;
   logic            hazard;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;

   assign ex_we = e_q.valid & e_q.wreg;

`ifdef FWD_EN
   logic hit_a;
   logic hit_b;

   fwd_mux u_fwd_a (
      .src_i(rs), .used_i(rs_used),
      .ex_we_i(ex_we), .ex_wn_i(e_q.wn), .ex_alu_i(ex_alu),
      .mem_we_i(mem_wreg), .mem_wn_i(mem_wn), .mem_m2reg_i(mem_m2reg),
      .mem_alu_i(mem_alu), .mem_dout_i(mem_dout),
      .wb_we_i(wb_we), .wb_wn_i(wb_wn), .wb_d_i(wb_d),
      .q_i(qa), .ex_hit_o(hit_a), .d_o(op_a)
   );

   fwd_mux u_fwd_b (
      .src_i(rt), .used_i(rt_used),
      .ex_we_i(ex_we), .ex_wn_i(e_q.wn), .ex_alu_i(ex_alu),
      .mem_we_i(mem_wreg), .mem_wn_i(mem_wn), .mem_m2reg_i(mem_m2reg),
      .mem_alu_i(mem_alu), .mem_dout_i(mem_dout),
      .wb_we_i(wb_we), .wb_wn_i(wb_wn), .wb_d_i(wb_d),
      .q_i(qb), .ex_hit_o(hit_b), .d_o(op_b)
   );

   // A load in EX has no data yet; everything else can be bypassed.
   assign hazard = e_q.m2reg & (hit_a | hit_b);
`else
   logic unused_fwd_data;

   assign op_a = qa;
   assign op_b = qb;

   // WB counts too: the register file writes on the same edge we sample.
   assign hazard = writer_hit(ex_we,    e_q.wn, rs, rs_used)
                 | writer_hit(ex_we,    e_q.wn, rt, rt_used)
                 | writer_hit(mem_wreg, mem_wn, rs, rs_used)
                 | writer_hit(mem_wreg, mem_wn, rt, rt_used)
                 | writer_hit(wb_we,    wb_wn,  rs, rs_used)
                 | writer_hit(wb_we,    wb_wn,  rt, rt_used);

   assign unused_fwd_data = ^{ex_alu, mem_alu, mem_dout, wb_d, mem_m2reg};
`endif

   // A flushed or empty slot never holds the front end; stall also drops
   // the moment reset asserts.
   assign stall = clrn & id_valid & ~flush & hazard;

   always_comb begin
      e_d = ID_EX_BUBBLE;
      if (id_valid && !flush && !hazard) begin
         e_d.valid = 1'b1;
         e_d.wreg  = id_wreg;
         e_d.m2reg = id_m2reg;
         e_d.wn    = id_wn;
         e_d.ctrl  = id_ctrl;
         e_d.a     = op_a;
         e_d.b     = op_b;
         e_d.imm   = id_imm;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         e_q <= ID_EX_BUBBLE;
      else
         e_q <= e_d;
   end

   assign ea      = e_q.a;
   assign eb      = e_q.b;
   assign e_imm   = e_q.imm;
   assign e_ctrl  = e_q.ctrl;
   assign e_wn    = e_q.wn;
   assign e_wreg  = e_q.wreg;
   assign e_m2reg = e_q.m2reg;
   assign e_valid = e_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
   import pipe_pkg::*;

`ifdef FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              clrn;
   logic [4:0]        rs, rt, id_wn, mem_wn, wb_wn;
   logic              rs_used, rt_used, id_wreg, id_m2reg, id_valid;
   logic              mem_wreg, mem_m2reg, wb_we, flush;
   logic [XLEN-1:0]   qa, qb, id_imm, ex_alu, mem_alu, mem_dout, wb_d;
   logic [CTRL_W-1:0] id_ctrl;
   logic              stall, e_wreg, e_m2reg, e_valid;
   logic [XLEN-1:0]   ea, eb, e_imm;
   logic [CTRL_W-1:0] e_ctrl;
   logic [4:0]        e_wn;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
      .qa(qa), .qb(qb), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_wn(id_wn),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_valid(id_valid), .ex_alu(ex_alu),
      .mem_wn(mem_wn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_alu(mem_alu),
      .mem_dout(mem_dout), .wb_wn(wb_wn), .wb_we(wb_we), .wb_d(wb_d), .flush(flush),
      .stall(stall), .ea(ea), .eb(eb), .e_imm(e_imm), .e_ctrl(e_ctrl), .e_wn(e_wn),
      .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_valid(e_valid)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      rs = 0; rt = 0; rs_used = 0; rt_used = 0; qa = 0; qb = 0;
      id_imm = 0; id_ctrl = 0; id_wn = 0; id_wreg = 0; id_m2reg = 0; id_valid = 0;
      ex_alu = 0; mem_wn = 0; mem_wreg = 0; mem_m2reg = 0; mem_alu = 0; mem_dout = 0;
      wb_wn = 0; wb_we = 0; wb_d = 0; flush = 0;
   endtask

   // Leaves inputs idle, reset released, time = negedge + 2.
   task automatic do_reset();
      @(negedge clk);
      idle();
      clrn = 1'b0;
      #2;
      clrn = 1'b1;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   // Put "lw $4" into ID/EX.
   task automatic load_lw4();
      id_valid = 1; id_wn = 4; id_wreg = 1; id_m2reg = 1; rs = 1; rs_used = 1;
      edge_sample();
      @(negedge clk);
      id_m2reg = 0; id_wn = 8;
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic [4:0]  rs, rt;
      logic        rs_used, rt_used, id_valid, flush;
      logic [31:0] qa, qb;
      logic [4:0]  mem_wn;
      logic        mem_wreg, mem_m2reg;
      logic [31:0] mem_alu, mem_dout;
      logic [4:0]  wb_wn;
      logic        wb_we;
      logic [31:0] wb_d;
      logic        x_stall, x_valid;
      logic [31:0] x_ea, x_eb;
   } vec_t;

   vec_t vt[11];
   vec_t base;

   // ---------------- reference model ----------------
   typedef struct {
      logic        we;
      logic [4:0]  wn;
      logic [31:0] val;
      logic        load;
   } wr_t;

   wr_t         wr[3];
   logic        m_valid, m_wreg, m_m2reg;
   logic [4:0]  m_wn;
   logic [31:0] m_ea, m_eb, m_imm;
   logic [7:0]  m_ctrl;

   function automatic int first_writer(input logic [4:0] s, input logic used);
      for (int k = 0; k < 3; k++)
         if (used && s != 0 && wr[k].we && wr[k].wn == s) return k;
      return 3;
   endfunction

   function automatic logic [31:0] src_val(input int k, input logic [31:0] q);
      return (k < 3) ? wr[k].val : q;
   endfunction

   initial begin
      logic        x_st;
      int          ka, kb;
      idle();
      clrn = 1'b1;

      // ---------- reset ----------
      @(negedge clk);
      id_valid = 1; id_wn = 9; id_wreg = 1; id_imm = 32'h1234; id_ctrl = 8'h5A;
      rs = 1; rs_used = 1; qa = 32'h10; mem_wn = 1; mem_wreg = 1;
      clrn = 1'b0;
      #1;
      chk("rst stall", stall, 0);
      chk("rst e_valid", e_valid, 0);
      chk("rst e_imm", e_imm, 0);
      chk("rst e_ctrl", e_ctrl, 0);
      chk("rst ea", ea, 0);
      edge_sample();
      chk("rst held e_valid", e_valid, 0);
      @(negedge clk);
      mem_wreg = 0;
      clrn = 1'b1;
      edge_sample();
      chk("post-rst e_valid", e_valid, 1);
      chk("post-rst e_imm", e_imm, 32'h1234);
      chk("post-rst e_ctrl", e_ctrl, 8'h5A);
      chk("post-rst e_wn", e_wn, 9);
      chk("post-rst e_wreg", e_wreg, 1);
      chk("post-rst ea", ea, 32'h10);

      // ---------- table ----------
      base = '{rs: 5'd1, rt: 5'd2, rs_used: 1'b1, rt_used: 1'b1, id_valid: 1'b1, flush: 1'b0,
               qa: 32'h10, qb: 32'h20, mem_wn: 5'd0, mem_wreg: 1'b0, mem_m2reg: 1'b0,
               mem_alu: 32'h0, mem_dout: 32'h0, wb_wn: 5'd0, wb_we: 1'b0, wb_d: 32'h0,
               x_stall: 1'b0, x_valid: 1'b1, x_ea: 32'h10, x_eb: 32'h20};
      for (int i = 0; i < 11; i++) vt[i] = base;
      // MEM ALU result to rs
      vt[1].mem_wn = 1; vt[1].mem_wreg = 1; vt[1].mem_alu = 32'h2; vt[1].mem_dout = 32'h99;
      vt[1].x_stall = !FWD; vt[1].x_valid = FWD;
      vt[1].x_ea = FWD ? 32'h2 : 32'h0; vt[1].x_eb = FWD ? 32'h20 : 32'h0;
      // MEM load data to rt
      vt[2].mem_wn = 2; vt[2].mem_wreg = 1; vt[2].mem_m2reg = 1;
      vt[2].mem_alu = 32'h77; vt[2].mem_dout = 32'hA5;
      vt[2].x_stall = !FWD; vt[2].x_valid = FWD;
      vt[2].x_ea = FWD ? 32'h10 : 32'h0; vt[2].x_eb = FWD ? 32'hA5 : 32'h0;
      // WB to rs
      vt[3].wb_wn = 1; vt[3].wb_we = 1; vt[3].wb_d = 32'h3;
      vt[3].x_stall = !FWD; vt[3].x_valid = FWD;
      vt[3].x_ea = FWD ? 32'h3 : 32'h0; vt[3].x_eb = FWD ? 32'h20 : 32'h0;
      // MEM beats WB on rt
      vt[4].mem_wn = 2; vt[4].mem_wreg = 1; vt[4].mem_alu = 32'h2;
      vt[4].wb_wn = 2; vt[4].wb_we = 1; vt[4].wb_d = 32'h3;
      vt[4].x_stall = !FWD; vt[4].x_valid = FWD;
      vt[4].x_ea = FWD ? 32'h10 : 32'h0; vt[4].x_eb = FWD ? 32'h2 : 32'h0;
      // $0 never forwarded
      vt[5].rs = 0; vt[5].qa = 0; vt[5].wb_wn = 0; vt[5].wb_we = 1; vt[5].wb_d = 32'hFF;
      vt[5].mem_wn = 0; vt[5].mem_wreg = 1; vt[5].mem_alu = 32'hEE;
      vt[5].x_ea = 32'h0;
      // unused source ignores writer
      vt[6].rs_used = 0; vt[6].mem_wn = 1; vt[6].mem_wreg = 1; vt[6].mem_alu = 32'h2;
      // empty slot
      vt[7].id_valid = 0; vt[7].mem_wn = 1; vt[7].mem_wreg = 1;
      vt[7].x_valid = 0; vt[7].x_ea = 0; vt[7].x_eb = 0;
      // flush
      vt[8].flush = 1; vt[8].mem_wn = 1; vt[8].mem_wreg = 1;
      vt[8].x_valid = 0; vt[8].x_ea = 0; vt[8].x_eb = 0;
      // disabled writers
      vt[9].wb_wn = 1; vt[9].wb_d = 32'h3;
      vt[10].mem_wn = 1; vt[10].mem_alu = 32'h2;

      for (int i = 0; i < 11; i++) begin
         do_reset();
         rs = vt[i].rs; rt = vt[i].rt; rs_used = vt[i].rs_used; rt_used = vt[i].rt_used;
         id_valid = vt[i].id_valid; flush = vt[i].flush; qa = vt[i].qa; qb = vt[i].qb;
         mem_wn = vt[i].mem_wn; mem_wreg = vt[i].mem_wreg; mem_m2reg = vt[i].mem_m2reg;
         mem_alu = vt[i].mem_alu; mem_dout = vt[i].mem_dout;
         wb_wn = vt[i].wb_wn; wb_we = vt[i].wb_we; wb_d = vt[i].wb_d;
         id_wn = 7; id_wreg = 1;
         #1;
         chk($sformatf("vec%0d stall", i), stall, vt[i].x_stall);
         edge_sample();
         chk($sformatf("vec%0d e_valid", i), e_valid, vt[i].x_valid);
         chk($sformatf("vec%0d ea", i), ea, vt[i].x_ea);
         chk($sformatf("vec%0d eb", i), eb, vt[i].x_eb);
      end

      // ---------- EX bypass / writer walk ----------
      do_reset();
      id_valid = 1; id_wn = 3; id_wreg = 1; rs = 1; rt = 2; rs_used = 1; rt_used = 1;
      qa = 32'h10; qb = 32'h20;
      edge_sample();
      @(negedge clk);
      rs = 3; qa = 32'h33; ex_alu = 32'h55; id_wn = 6;
      #1;
      chk("exbyp stall", stall, !FWD);
`ifdef FWD_EN
      edge_sample();
      chk("exbyp ea", ea, 32'h55);
      chk("exbyp e_valid", e_valid, 1);
`else
      edge_sample();
      chk("exbyp bubble", e_valid, 0);
      @(negedge clk);
      mem_wn = 3; mem_wreg = 1; mem_alu = 32'h55;
      #1;
      chk("exbyp mem stall", stall, 1);
      edge_sample();
      @(negedge clk);
      mem_wreg = 0; wb_wn = 3; wb_we = 1; wb_d = 32'h55;
      #1;
      chk("exbyp wb stall", stall, 1);
      edge_sample();
      @(negedge clk);
      wb_we = 0; qa = 32'h55;
      #1;
      chk("exbyp clear stall", stall, 0);
      edge_sample();
      chk("exbyp ea", ea, 32'h55);
      chk("exbyp e_valid", e_valid, 1);
`endif

      // ---------- load-use ----------
      do_reset();
      load_lw4();
      rt = 4; rt_used = 1; qb = 32'h44;
      #1;
      chk("lu stall", stall, 1);
      edge_sample();
      chk("lu bubble e_valid", e_valid, 0);
      chk("lu bubble e_wn", e_wn, 0);
      @(negedge clk);
      mem_wn = 4; mem_wreg = 1; mem_m2reg = 1; mem_dout = 32'hA5; mem_alu = 32'h10;
      #1;
      chk("lu 2nd stall", stall, !FWD);
`ifdef FWD_EN
      edge_sample();
      chk("lu eb", eb, 32'hA5);
      chk("lu e_valid", e_valid, 1);
`else
      edge_sample();
      @(negedge clk);
      mem_wreg = 0; wb_wn = 4; wb_we = 1; wb_d = 32'hA5;
      #1;
      chk("lu wb stall", stall, 1);
      edge_sample();
      @(negedge clk);
      wb_we = 0; qb = 32'hA5;
      #1;
      chk("lu clear stall", stall, 0);
      edge_sample();
      chk("lu eb", eb, 32'hA5);
      chk("lu e_valid", e_valid, 1);
`endif

      // ---------- priority EX > MEM > WB ----------
      do_reset();
      id_valid = 1; id_wn = 5; id_wreg = 1;
      edge_sample();
      @(negedge clk);
      rs = 5; rs_used = 1; qa = 32'h99; ex_alu = 32'h1;
      mem_wn = 5; mem_wreg = 1; mem_alu = 32'h2; wb_wn = 5; wb_we = 1; wb_d = 32'h3;
      id_wn = 9; id_wreg = 0;
      #1;
      chk("prio stall", stall, !FWD);
`ifdef FWD_EN
      edge_sample();
      chk("prio ex", ea, 32'h1);
      edge_sample();
      chk("prio mem", ea, 32'h2);
      @(negedge clk);
      mem_wreg = 0;
      edge_sample();
      chk("prio wb", ea, 32'h3);
`endif

      // ---------- flush beats load-use ----------
      do_reset();
      load_lw4();
      rt = 4; rt_used = 1; flush = 1;
      #1;
      chk("flush stall", stall, 0);
      edge_sample();
      chk("flush bubble", e_valid, 0);
      @(negedge clk);
      flush = 0; rt = 2; id_wreg = 1; qb = 32'h20;
      #1;
      chk("after flush stall", stall, 0);
      edge_sample();
      chk("after flush e_valid", e_valid, 1);
      chk("after flush e_wn", e_wn, 8);
      chk("after flush eb", eb, 32'h20);

      // ---------- reset during stall ----------
      do_reset();
      load_lw4();
      rt = 4; rt_used = 1;
      #1;
      chk("midrst stall before", stall, 1);
      clrn = 1'b0;
      #1;
      chk("midrst stall", stall, 0);
      chk("midrst e_valid", e_valid, 0);
      #1;
      clrn = 1'b1;

      // ---------- randomized vs model ----------
      do_reset();
      m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wn = 0; m_ea = 0; m_eb = 0; m_imm = 0; m_ctrl = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
         rs_used = ($urandom_range(0, 7) != 0); rt_used = ($urandom_range(0, 3) != 0);
         qa = $urandom; qb = $urandom; id_imm = $urandom; id_ctrl = 8'($urandom);
         id_wn = 5'($urandom_range(0, 3)); id_wreg = ($urandom_range(0, 3) != 0);
         id_m2reg = ($urandom_range(0, 2) == 0); id_valid = ($urandom_range(0, 7) != 0);
         ex_alu = $urandom;
         mem_wn = 5'($urandom_range(0, 3)); mem_wreg = ($urandom_range(0, 2) == 0);
         mem_m2reg = $urandom_range(0, 1); mem_alu = $urandom; mem_dout = $urandom;
         wb_wn = 5'($urandom_range(0, 3)); wb_we = ($urandom_range(0, 2) == 0); wb_d = $urandom;
         flush = ($urandom_range(0, 9) == 0);
         wr[0] = '{we: m_valid && m_wreg, wn: m_wn, val: ex_alu, load: m_m2reg};
         wr[1] = '{we: mem_wreg, wn: mem_wn, val: mem_m2reg ? mem_dout : mem_alu, load: 1'b0};
         wr[2] = '{we: wb_we, wn: wb_wn, val: wb_d, load: 1'b0};
         ka = first_writer(rs, rs_used);
         kb = first_writer(rt, rt_used);
         x_st = FWD ? ((ka == 0 || kb == 0) && wr[0].load) : (ka < 3 || kb < 3);
         x_st = x_st && id_valid && !flush;
         #1;
         chk($sformatf("rnd%0d stall", c), stall, x_st);
         @(posedge clk);
         if (!id_valid || flush || x_st) begin
            m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wn = 0;
            m_ea = 0; m_eb = 0; m_imm = 0; m_ctrl = 0;
         end else begin
            m_valid = 1; m_wreg = id_wreg; m_m2reg = id_m2reg; m_wn = id_wn;
            m_ea = FWD ? src_val(ka, qa) : qa;
            m_eb = FWD ? src_val(kb, qb) : qb;
            m_imm = id_imm; m_ctrl = id_ctrl;
         end
         #1;
         chk($sformatf("rnd%0d e_valid", c), e_valid, m_valid);
         chk($sformatf("rnd%0d e_wreg", c), e_wreg, m_wreg);
         chk($sformatf("rnd%0d e_m2reg", c), e_m2reg, m_m2reg);
         chk($sformatf("rnd%0d e_wn", c), e_wn, m_wn);
         chk($sformatf("rnd%0d ea", c), ea, m_ea);
         chk($sformatf("rnd%0d eb", c), eb, m_eb);
         chk($sformatf("rnd%0d e_imm", c), e_imm, m_imm);
         chk($sformatf("rnd%0d e_ctrl", c), e_ctrl, m_ctrl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
